// File: rtl/message_writer_if.sv
// Handshake and read-port bundle between the input stage, the message writer and the display reader.
interface message_writer_if #(
  parameter int DATA_W = 4
);
  logic              start;
  logic              char_valid;
  logic [DATA_W-1:0] char_in;
  logic              finish;
  logic [3:0]        rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [3:0]        wr_addr;
  logic [4:0]        msg_len;
  logic              busy;
  logic              ready;

  modport master (
    output start, char_valid, char_in, finish, rd_addr,
    input  rd_data, wr_addr, msg_len, busy, ready
  );

  modport slave (
    input  start, char_valid, char_in, finish, rd_addr,
    output rd_data, wr_addr, msg_len, busy, ready
  );
endinterface

// File: rtl/message_writer.sv
// Write side of the 16-entry scrolling-message store: loads characters, blank-pads the tail, flags ready.
// Writes land on the sampling edge; rd_data is a combinational read; no backpressure, inputs outside LOAD are ignored.
module message_writer #(
  parameter int                DATA_W = 4,
  parameter logic [DATA_W-1:0] BLANK  = {DATA_W{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  message_writer_if.slave  bus
);

  localparam int DEPTH = 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_PAD   = 2'd2;
  localparam logic [1:0] S_READY = 2'd3;

  logic [1:0]        state;
  logic [3:0]        wr_addr;
  logic [4:0]        msg_len;
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      wr_addr <= '0;
      msg_len <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= BLANK;
      end
    end else begin
      case (state)
        S_IDLE, S_READY: begin
          if (bus.start) begin
            state   <= S_LOAD;
            wr_addr <= '0;
            msg_len <= '0;
          end
        end
        S_LOAD: begin
          // start outranks char_valid, which outranks finish
          if (bus.start) begin
            wr_addr <= '0;
            msg_len <= '0;
          end else if (bus.char_valid) begin
            mem[wr_addr] <= bus.char_in;
            wr_addr      <= wr_addr + 4'd1;
            msg_len      <= msg_len + 5'd1;
            if (wr_addr == 4'd15) begin
              state <= S_READY;
            end else if (bus.finish) begin
              state <= S_PAD;
            end
          end else if (bus.finish) begin
            state <= S_PAD;
          end
        end
        S_PAD: begin
          mem[wr_addr] <= BLANK;
          wr_addr      <= wr_addr + 4'd1;
          if (wr_addr == 4'd15) begin
            state <= S_READY;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Status bits are straight decodes of the state flop, so they can never overlap.
  assign bus.busy    = (state == S_LOAD) || (state == S_PAD);
  assign bus.ready   = (state == S_READY);
  assign bus.wr_addr = wr_addr;
  assign bus.msg_len = msg_len;
  assign bus.rd_data = mem[bus.rd_addr];

endmodule

// File: tb/tb_message_writer.sv
// Directed-plus-random bench for message_writer; expectations come from the message contents and padding rules.
module tb_message_writer;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  logic [3:0] exp_mem [16];
  logic [3:0] q [$];

  message_writer_if #(.DATA_W(4)) bus ();

  message_writer #(.DATA_W(4), .BLANK(4'hF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic s, input logic cv, input logic [3:0] ch, input logic f);
    @(negedge clk);
    bus.start      = s;
    bus.char_valid = cv;
    bus.char_in    = ch;
    bus.finish     = f;
    @(posedge clk);
    #1;
    bus.start      = 1'b0;
    bus.char_valid = 1'b0;
    bus.finish     = 1'b0;
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 16; i++) begin
      bus.rd_addr = i[3:0];
      #1;
      chk($sformatf("%s_mem%0d", tag, i), {28'd0, bus.rd_data}, {28'd0, exp_mem[i]});
    end
  endtask

  task automatic check_status(input string tag, input int len, input int wa, input logic b, input logic r);
    chk({tag, "_msg_len"}, {27'd0, bus.msg_len}, len);
    chk({tag, "_wr_addr"}, {28'd0, bus.wr_addr}, wa);
    chk({tag, "_busy"},    {31'd0, bus.busy},    {31'd0, b});
    chk({tag, "_ready"},   {31'd0, bus.ready},   {31'd0, r});
  endtask

  // Idle cycles until ready rises; returns how many were needed (bounded).
  task automatic pad_until_ready(output int k);
    k = 0;
    while (!bus.ready && k < 40) begin
      cyc(1'b0, 1'b0, 4'd0, 1'b0);
      k++;
    end
  endtask

  // Load the queued characters, optionally with idle gaps, then finish and check padding.
  task automatic load_and_finish(input string tag, input logic gaps);
    int k;
    int n;
    n = q.size();
    cyc(1'b1, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) cyc(1'b0, 1'b0, 4'd0, 1'b0);
      cyc(1'b0, 1'b1, q[i], 1'b0);
    end
    chk({tag, "_wr_addr_pre"}, {28'd0, bus.wr_addr}, n);
    cyc(1'b0, 1'b0, 4'd0, 1'b1);
    chk({tag, "_busy_pad"}, {31'd0, bus.busy}, 1);
    pad_until_ready(k);
    chk({tag, "_pad_cycles"}, k, 16 - n);
    for (int i = 0; i < 16; i++) exp_mem[i] = (i < n) ? q[i] : 4'hF;
    check_status(tag, n, 0, 1'b0, 1'b1);
    check_mem(tag);
  endtask

  initial begin
    int k;
    logic [3:0] a;
    logic [3:0] b;
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.char_valid = 1'b0;
    bus.char_in = 4'd0;
    bus.finish = 1'b0;
    bus.rd_addr = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;

    // Reset state
    for (int i = 0; i < 16; i++) exp_mem[i] = 4'hF;
    check_status("rst", 0, 0, 1'b0, 1'b0);
    check_mem("rst");

    // Full 16-character load, ready on the 16th edge with no pad cycle
    cyc(1'b1, 1'b0, 4'd0, 1'b0);
    chk("full_busy_after_start", {31'd0, bus.busy}, 1);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, i[3:0], 1'b0);
      if (i == 14) chk("full_ready_before_last", {31'd0, bus.ready}, 0);
      exp_mem[i] = i[3:0];
    end
    check_status("full", 16, 0, 1'b0, 1'b1);
    check_mem("full");

    // READY ignores char_valid and finish
    cyc(1'b0, 1'b1, 4'($urandom_range(0, 15)), 1'b0);
    cyc(1'b0, 1'b0, 4'd0, 1'b1);
    check_status("ready_hold", 16, 0, 1'b0, 1'b1);
    check_mem("ready_hold");

    // Short message 3,7,2 then finish: 13 pad cycles
    q = {4'd3, 4'd7, 4'd2};
    load_and_finish("short", 1'b0);

    // Randomised message lengths, including an empty message
    for (int t = 0; t < 4; t++) begin
      int n;
      n = (t == 0) ? 0 : $urandom_range(1, 15);
      q = {};
      for (int i = 0; i < n; i++) q.push_back(4'($urandom_range(0, 15)));
      load_and_finish($sformatf("rnd%0d", t), 1'b1);
    end

    // char_valid and finish together on entry 15: straight to READY
    cyc(1'b1, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      exp_mem[i] = 4'($urandom_range(0, 15));
      cyc(1'b0, 1'b1, exp_mem[i], 1'b0);
    end
    chk("cvfin_len15", {27'd0, bus.msg_len}, 15);
    cyc(1'b0, 1'b1, 4'd9, 1'b1);
    exp_mem[15] = 4'd9;
    check_status("cvfin", 16, 0, 1'b0, 1'b1);
    check_mem("cvfin");

    // start beats char_valid in LOAD: restart, no write, old entries kept
    a = 4'($urandom_range(0, 15));
    b = 4'($urandom_range(0, 15));
    cyc(1'b1, 1'b0, 4'd0, 1'b0);
    cyc(1'b0, 1'b1, a, 1'b0);
    cyc(1'b0, 1'b1, b, 1'b0);
    exp_mem[0] = a;
    exp_mem[1] = b;
    cyc(1'b1, 1'b1, ~a, 1'b1);
    check_status("restart", 0, 0, 1'b1, 1'b0);
    check_mem("restart");

    // Reset in the middle of padding at wr_addr 6
    cyc(1'b1, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 4'd5, 1'b0);
    cyc(1'b0, 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 4'd0, 1'b0);
    check_status("pad6", 3, 6, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    check_status("midrst", 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) exp_mem[i] = 4'hF;
    check_mem("midrst");
    @(negedge clk);
    reset = 1'b0;

    // Normal operation after the mid-pad reset
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(4'($urandom_range(0, 15)));
    cyc(1'b1, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, q[i], 1'b0);
      exp_mem[i] = q[i];
    end
    check_status("postrst", 16, 0, 1'b0, 1'b1);
    check_mem("postrst");

    // start from READY: busy next cycle, ready drops
    cyc(1'b1, 1'b0, 4'd0, 1'b0);
    check_status("rdy_start", 0, 0, 1'b1, 1'b0);
    pad_until_ready(k);
    chk("load_no_timeout_ready", {31'd0, bus.ready}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
